// File: rtl/layer_compositor.sv
// Raster-scan compositor: issues pixel requests, waits READ_LATENCY cycles for
// layer/cursor data, then picks the highest-priority opaque source per pixel.
module layer_compositor #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int LAYERS       = 4,
  parameter int COLOR_WIDTH  = 4,
  parameter int READ_LATENCY = 1,
  parameter int TRANSPARENT  = 0,
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int AW = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          solo,
  input  logic [AW-1:0]                 active_layer,
  input  logic [LAYERS-1:0]             visible,
  input  logic                          cursor_visible,
  input  logic [COLOR_WIDTH-1:0]        background_color,
  input  logic [LAYERS*COLOR_WIDTH-1:0] layer_colors,
  input  logic [COLOR_WIDTH-1:0]        cursor_color,
  output logic [XW-1:0]                 request_x,
  output logic [YW-1:0]                 request_y,
  output logic [XW-1:0]                 render_x,
  output logic [YW-1:0]                 render_y,
  output logic [COLOR_WIDTH-1:0]        render_color,
  output logic                          render_valid,
  output logic                          frame_done
);

  localparam logic [COLOR_WIDTH-1:0] TRANSP = COLOR_WIDTH'(TRANSPARENT);
  localparam logic [XW-1:0]          X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]          Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] req_x_q, req_x_d;
  logic [YW-1:0] req_y_q, req_y_d;

  always_comb begin
    req_x_d = req_x_q;
    req_y_d = req_y_q;
    if (enable) begin
      if (req_x_q == X_LAST) begin
        req_x_d = '0;
        req_y_d = (req_y_q == Y_LAST) ? '0 : req_y_q + YW'(1);
      end else begin
        req_x_d = req_x_q + XW'(1);
      end
    end
  end

  // Delay line: each slot carries the request coordinate until its data returns.
  logic          pipe_valid_q [READ_LATENCY];
  logic          pipe_valid_d [READ_LATENCY];
  logic [XW-1:0] pipe_x_q     [READ_LATENCY];
  logic [XW-1:0] pipe_x_d     [READ_LATENCY];
  logic [YW-1:0] pipe_y_q     [READ_LATENCY];
  logic [YW-1:0] pipe_y_d     [READ_LATENCY];

  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_valid_d[gi] = enable;
        assign pipe_x_d[gi]     = req_x_q;
        assign pipe_y_d[gi]     = req_y_q;
      end else begin : g_tail
        assign pipe_valid_d[gi] = pipe_valid_q[gi-1];
        assign pipe_x_d[gi]     = pipe_x_q[gi-1];
        assign pipe_y_d[gi]     = pipe_y_q[gi-1];
      end
    end
  endgenerate

  logic          exit_valid;
  logic [XW-1:0] exit_x;
  logic [YW-1:0] exit_y;

  assign exit_valid = pipe_valid_q[READ_LATENCY-1];
  assign exit_x     = pipe_x_q[READ_LATENCY-1];
  assign exit_y     = pipe_y_q[READ_LATENCY-1];

  // An out-of-range active_layer never matches any index, leaving only cursor/background.
  logic [LAYERS-1:0] layer_on;

  generate
    for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
      assign layer_on[gi] = (solo ? (active_layer == AW'(gi)) : visible[gi]) &&
                            (layer_colors[gi*COLOR_WIDTH +: COLOR_WIDTH] != TRANSP);
    end
  endgenerate

  logic [COLOR_WIDTH-1:0] color_sel;

  always_comb begin
    color_sel = background_color;
    for (int i = 0; i < LAYERS; i++) begin
      if (layer_on[i]) color_sel = layer_colors[i*COLOR_WIDTH +: COLOR_WIDTH];
    end
    if (cursor_visible && (cursor_color != TRANSP)) color_sel = cursor_color;
  end

  logic [XW-1:0]          render_x_q, render_x_d;
  logic [YW-1:0]          render_y_q, render_y_d;
  logic [COLOR_WIDTH-1:0] render_color_q, render_color_d;
  logic                   render_valid_q, render_valid_d;
  logic                   frame_done_q, frame_done_d;

  always_comb begin
    render_valid_d = exit_valid;
    render_x_d     = render_x_q;
    render_y_d     = render_y_q;
    render_color_d = render_color_q;
    frame_done_d   = exit_valid && (exit_x == X_LAST) && (exit_y == Y_LAST);
    if (exit_valid) begin
      render_x_d     = exit_x;
      render_y_d     = exit_y;
      render_color_d = color_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_x_q        <= '0;
      req_y_q        <= '0;
      render_x_q     <= '0;
      render_y_q     <= '0;
      render_color_q <= '0;
      render_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_x_q[i]     <= '0;
        pipe_y_q[i]     <= '0;
      end
    end else begin
      req_x_q        <= req_x_d;
      req_y_q        <= req_y_d;
      render_x_q     <= render_x_d;
      render_y_q     <= render_y_d;
      render_color_q <= render_color_d;
      render_valid_q <= render_valid_d;
      frame_done_q   <= frame_done_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_x_q[i]     <= pipe_x_d[i];
        pipe_y_q[i]     <= pipe_y_d[i];
      end
    end
  end

  assign request_x    = req_x_q;
  assign request_y    = req_y_q;
  assign render_x     = render_x_q;
  assign render_y     = render_y_q;
  assign render_color = render_color_q;
  assign render_valid = render_valid_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Randomized and directed checks of layer_compositor against a pixel-queue
// reference model using the small 4x2, 3-layer configuration.
module tb_layer_compositor;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int L  = 3;
  localparam int CW = 4;
  localparam int RL = 1;
  localparam int TR = 0;
  localparam int XW = 2;
  localparam int YW = 1;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          solo = 1'b0;
  logic [AW-1:0] active_layer = '0;
  logic [L-1:0]  visible = '0;
  logic          cursor_visible = 1'b0;
  logic [CW-1:0] background_color = '0;
  logic [L*CW-1:0] layer_colors = '0;
  logic [CW-1:0] cursor_color = '0;
  logic [XW-1:0] request_x, render_x;
  logic [YW-1:0] request_y, render_y;
  logic [CW-1:0] render_color;
  logic          render_valid, frame_done;

  layer_compositor #(
    .WIDTH(W), .HEIGHT(H), .LAYERS(L), .COLOR_WIDTH(CW),
    .READ_LATENCY(RL), .TRANSPARENT(TR)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .solo(solo),
    .active_layer(active_layer), .visible(visible),
    .cursor_visible(cursor_visible), .background_color(background_color),
    .layer_colors(layer_colors), .cursor_color(cursor_color),
    .request_x(request_x), .request_y(request_y),
    .render_x(render_x), .render_y(render_y), .render_color(render_color),
    .render_valid(render_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { bit en; int pix; } slot_t;
  slot_t slots[$];
  int mdl_pix = 0;
  bit e_valid = 0, e_done = 0;
  int e_x = 0, e_y = 0, e_c = 0;

  // Priority: opaque cursor, then highest shown opaque layer, then background.
  function automatic int ref_color();
    if (cursor_visible && int'(cursor_color) != TR) return int'(cursor_color);
    for (int i = L - 1; i >= 0; i--) begin
      bit shown;
      int c;
      shown = solo ? (int'(active_layer) == i) : visible[i];
      c = int'((layer_colors >> (i * CW)) & 12'hF);
      if (shown && c != TR) return c;
    end
    return int'(background_color);
  endfunction

  function automatic logic [CW-1:0] rand_color();
    if ($urandom_range(0, 3) == 0) return '0;
    return CW'($urandom_range(1, 15));
  endfunction

  task automatic check_outputs();
    check_eq("request_x", request_x, mdl_pix % W);
    check_eq("request_y", request_y, mdl_pix / W);
    check_eq("render_valid", render_valid, e_valid);
    check_eq("frame_done", frame_done, e_done);
    check_eq("render_x", render_x, e_x);
    check_eq("render_y", render_y, e_y);
    check_eq("render_color", render_color, e_c);
    if (render_valid)
      $display("render (%0d,%0d) color %0d frame_done %0d", render_x, render_y, render_color, frame_done);
  endtask

  // Inputs are already set; model the posedge that consumes them, then check.
  task automatic cycle();
    slot_t s;
    s.en = enable;
    s.pix = mdl_pix;
    slots.push_back(s);
    e_valid = 0;
    e_done = 0;
    if (slots.size() > RL) begin
      s = slots.pop_front();
      e_valid = s.en;
      if (s.en) begin
        e_x = s.pix % W;
        e_y = s.pix / W;
        e_c = ref_color();
        e_done = (s.pix == W * H - 1);
      end
    end
    if (enable) mdl_pix = (mdl_pix + 1) % (W * H);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_valid", render_valid, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_color", render_color, 0);
    check_eq("rst_rx", render_x, 0);
    check_eq("rst_ry", render_y, 0);
    check_eq("rst_qx", request_x, 0);
    check_eq("rst_qy", request_y, 0);
    @(negedge clk);
    reset = 1'b1;
    slots.delete();
    mdl_pix = 0;
    e_valid = 0; e_done = 0; e_x = 0; e_y = 0; e_c = 0;
    check_outputs();
  endtask

  initial begin
    int guard;
    bit en_pat[6];
    #2;
    do_reset();

    // Empty layers, background only: one full frame plus wrap.
    background_color = 4'd5;
    enable = 1'b1;
    repeat (12) cycle();

    visible = 3'b111;
    layer_colors = {4'd0, 4'd7, 4'd3};
    repeat (2) cycle();
    check_eq("dir_vis111", render_color, 7);
    layer_colors = {4'd9, 4'd7, 4'd3};
    repeat (2) cycle();
    check_eq("dir_layer2", render_color, 9);
    visible = 3'b011;
    repeat (2) cycle();
    check_eq("dir_vis011", render_color, 7);

    solo = 1'b1;
    active_layer = 2'd0;
    repeat (2) cycle();
    check_eq("dir_solo0", render_color, 3);
    active_layer = 2'd3;
    repeat (2) cycle();
    check_eq("dir_solo_oob", render_color, 5);
    cursor_visible = 1'b1;
    cursor_color = 4'd4;
    repeat (2) cycle();
    check_eq("dir_cursor", render_color, 4);
    cursor_color = 4'd0;
    repeat (2) cycle();
    check_eq("dir_cursor_tr", render_color, 5);

    solo = 1'b0;
    cursor_visible = 1'b0;
    en_pat = '{1, 0, 0, 1, 1, 1};
    foreach (en_pat[i]) begin
      enable = en_pat[i];
      cycle();
    end
    enable = 1'b1;
    repeat (3) cycle();

    // Reset while pixel (2,0) is being requested.
    guard = 0;
    while (mdl_pix != 2 && guard < 20) begin
      cycle();
      guard++;
    end
    check_eq("reach_pix2", mdl_pix, 2);
    do_reset();
    repeat (8) cycle();

    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 4) != 0);
      solo = ($urandom_range(0, 3) == 0);
      active_layer = AW'($urandom_range(0, 3));
      visible = L'($urandom);
      cursor_visible = ($urandom_range(0, 2) == 0);
      cursor_color = rand_color();
      background_color = CW'($urandom_range(0, 15));
      for (int i = 0; i < L; i++) layer_colors[i*CW +: CW] = rand_color();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter WIDTH, default 640, horizontal pixel count.
REQ-002 Parameter HEIGHT, default 480, vertical pixel count.
REQ-003 Parameter LAYERS, default 4, number of canvas layers, range 1..8.
REQ-004 Parameter COLOR_WIDTH, default 4, color-index width.
REQ-005 Parameter READ_LATENCY, default 1, cycles from request_x/request_y to valid layer/cursor color, range 1..4.
REQ-006 Parameter TRANSPARENT, default 0, color index treated as see-through.
REQ-007 clk  input  1  single clock; all logic rising-edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 enable  input  1  scan advance; low freezes the request counter.
REQ-010 solo  input  1  high: show only layer active_layer, ignoring visible.
REQ-011 active_layer  input  $clog2(LAYERS) or 1 if LAYERS=1  layer shown in solo mode.
REQ-012 visible  input  LAYERS  per-layer visibility mask, bit i = layer i.
REQ-013 cursor_visible  input  1  cursor overlay enable.
REQ-014 background_color  input  COLOR_WIDTH  color where nothing opaque is present.
REQ-015 layer_colors  input  LAYERS*COLOR_WIDTH  layer i color at bits [i*COLOR_WIDTH +: COLOR_WIDTH], READ_LATENCY after request.
REQ-016 cursor_color  input  COLOR_WIDTH  cursor overlay color, READ_LATENCY after request.
REQ-017 request_x  output  $clog2(WIDTH)  column requested from layers/cursor.
REQ-018 request_y  output  $clog2(HEIGHT)  row requested from layers/cursor.
REQ-019 render_x, render_y  output  $clog2(WIDTH), $clog2(HEIGHT)  coordinate of render_color.
REQ-020 render_color  output  COLOR_WIDTH  composited pixel.
REQ-021 render_valid  output  1  render_x/render_y/render_color valid this cycle.
REQ-022 frame_done  output  1  one-cycle pulse with the last pixel (WIDTH-1, HEIGHT-1) of a frame.

Function
REQ-023 Request counter SHALL scan raster order: x increments each enabled cycle; at x=WIDTH-1, x wraps to 0 and y increments; at (WIDTH-1, HEIGHT-1) both wrap to 0.
REQ-024 enable low SHALL hold request_x/request_y unchanged and inject an invalid slot into the pipeline.
REQ-025 Each enabled cycle SHALL inject a valid slot tagged with the current request coordinate into a delay line of depth READ_LATENCY.
REQ-026 On the cycle a slot exits the delay line, layer_colors/cursor_color SHALL be sampled and composited; result registered, so total latency request -> render_valid = READ_LATENCY+1 cycles.
REQ-027 Layer i participates iff (solo ? i==active_layer : visible[i]) and its color != TRANSPARENT.
REQ-028 Priority, highest first: cursor (if cursor_visible and cursor_color != TRANSPARENT), layer LAYERS-1 down to layer 0, then background_color.
REQ-029 background_color SHALL be output even if equal to TRANSPARENT.
REQ-030 active_layer >= LAYERS in solo mode SHALL select no layer (background/cursor only).
REQ-031 Control inputs (solo, active_layer, visible, cursor_visible, background_color) SHALL be sampled at the compositing cycle, not at request time.
REQ-032 render_valid SHALL equal the exiting slot's valid bit, registered; render_x/render_y SHALL equal that slot's tag.
REQ-033 frame_done SHALL assert exactly with the render_valid cycle whose coordinate is (WIDTH-1, HEIGHT-1); never otherwise.
REQ-034 render_x/render_y/render_color SHALL hold their last value while render_valid is low.

Reset
REQ-035 reset low SHALL asynchronously clear request_x, request_y, render_x, render_y to 0, render_color to 0, render_valid and frame_done to 0, and all pipeline valid bits to 0.
REQ-036 After reset release, first request SHALL be (0,0) and first render_valid SHALL occur READ_LATENCY+1 enabled cycles later.
REQ-037 Reset mid-frame SHALL discard in-flight slots; no render_valid or frame_done from pre-reset requests.

Verification (WIDTH=4, HEIGHT=2, LAYERS=3, READ_LATENCY=1, TRANSPARENT=0)
REQ-038 Reset, enable=1, layers all 0, background=5 -> render_valid first at cycle 2 with (0,0) color 5; 8 pixels in raster order; frame_done only at (3,1); request wraps to (0,0).
REQ-039 visible=3'b111, layers {2:0,1:7,0:3}, cursor_visible=0 -> color 7; set layer2=9 -> 9; visible=3'b011 -> 7.
REQ-040 solo=1, active_layer=0, same colors -> 3; active_layer=3 -> background 5; cursor_visible=1, cursor_color=4 -> 4; cursor_color=0 -> 5.
REQ-041 enable toggled 1,0,0,1 -> request holds two cycles; render_valid low exactly two cycles, coordinates contiguous, no duplicates or skips.
REQ-042 Assert reset at pixel (2,0) for one cycle -> outputs 0 immediately, no stale render_valid, scan restarts at (0,0).
